issue_queue: RTL and testbench
==============================

# issue_queue

In-order issue buffer between `decode` and the execution units (ALU, PC_ALU, LSU). It is the parametrised successor of the combinational `issue` router. Decoded micro-ops are held in a DEPTH-entry FIFO. A register scoreboard blocks the head on read-after-write (RAW) hazards, and the head is dispatched over a per-unit req/ack handshake. Flush and writeback tracking are included so the block can sit in front of multi-cycle units.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `NUM_UNITS`, 3: dispatch ports (0=ALU, 1=PC_ALU, 2=LSU).
- `XLEN`, 32: immediate/PC width.
- `NREG`, 32: architectural registers; x0 is never tracked.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_i` in 1: decode presents a micro-op.
- `ack_o` out 1: micro-op accepted this cycle (`req_i && ack_o`).
- `unit_i` in $clog2(NUM_UNITS): target unit.
- `op_i` in 8: opaque operator code (pkg `alu_op`/`pc_op`/LSU op).
- `raddr_a_i`, `raddr_b_i` in 5: source registers.
- `use_a_i`, `use_b_i` in 1: source is read.
- `waddr_i` in 5: destination register.
- `we_i` in 1: instruction writes `waddr_i`.
- `imm_i` in XLEN: selected immediate.
- `pc_i` in XLEN: instruction PC.
- `unit_req_o` out NUM_UNITS: one-hot dispatch request.
- `unit_ack_i` in NUM_UNITS: unit accepts.
- `d_op_o`, `d_raddr_a_o`, `d_raddr_b_o`, `d_waddr_o`, `d_we_o`, `d_imm_o`, `d_pc_o` out: head payload; the unit reads the RF on acceptance.
- `wb_valid_i` in 1, `wb_addr_i` in 5: register writeback completes.
- `flush_i` in 1: discard all queued entries.
- `count_o` out $clog2(DEPTH)+1: occupancy.

## Operation
- **FIFO.**
  - Head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - A count register of $clog2(DEPTH)+1 bits tracks occupancy.
  - `ack_o = !full && !flush_i`. There is no pass-through when full, even if the head dispatches in the same cycle.
- **Hazard.**
  - Head is blocked if `(use_a && busy[raddr_a]) || (use_b && busy[raddr_b]) || (we && busy[waddr])`. The last term prevents WAW hazards.
  - `busy[0]` is always 0.
- **Dispatch.**
  - `unit_req_o[head.unit]` is asserted while the queue is non-empty and the head is not blocked.
  - Payload `d_*_o` always reflects the head entry.
  - Dispatch occurs on `unit_req_o[k] && unit_ack_i[k]`: head pops.
  - If `we && waddr!=0`, `busy[waddr]` is set.
  - `ack` on a unit not being requested is ignored.
- **Scoreboard.** `wb_valid_i` clears `busy[wb_addr_i]` at the clock edge. If a set and a clear hit the same register in the same cycle, the set wins.
- **Flush.**
  - `flush_i` empties the FIFO at the next edge: pointers are equalised and count goes to 0.
  - Dispatch and enqueue are suppressed in the flush cycle.
  - The scoreboard is kept, because in-flight writes still complete.
- **Simultaneous enqueue and dispatch.** When not full, count is unchanged and both pointers advance.
- **Reset.**
  - count=0, pointers=0, `busy` all 0.
  - `unit_req_o`=0; `d_*_o`=0 (entries reset to 0).
  - `ack_o`=0 while `rst_i` is asserted.
  - Reset mid-handshake drops the transaction.

## Timing
- Enqueue at edge N. The earliest `unit_req_o` is in cycle N+1 (registered entry; combinational hazard check).
- `unit_req_o` and payload stay stable until acked or flushed. A unit may hold `unit_ack_i` high in advance.
- Writeback at edge M unblocks a dependent head in cycle M+1 (no bypass).
- One dispatch per cycle maximum. Sustained throughput is 1/cycle with no hazards.

## Configuration
- `ISSUE_WB_BYPASS_EN`: when defined, the hazard check uses `busy & ~wb_clear_mask`. A writeback in cycle M unblocks a dependent head in the same cycle M, saving one cycle.
- Undefined: M+1 behaviour as above.
- Set-wins priority is unchanged in both builds.

## Structure
- Add to `pkg`:
  - `unit_sel_e` (UNIT_ALU, UNIT_PC_ALU, UNIT_LSU).
  - packed struct `issue_entry_t` {unit, op, raddr_a, raddr_b, use_a, use_b, waddr, we, imm, pc}.
  - constant `ISSUE_OP_W=8`.
- Sub-module `issue_scoreboard`: NREG busy bits, set/clear ports, two read-check ports plus a waddr check, and the bypass logic under the macro.

## Test plan
- **Reset/flow:** reset, then enqueue ALU op (raddr 1,2 → waddr 10) → `unit_req_o`=3'b001 next cycle; ack → count 0, `busy[10]`=1.
- **RAW:**
  - Stimulus: ALU writes x10, then LSU reads x10; unit 0 acks.
  - Response: LSU req stays low.
  - Then `wb_valid_i`, `wb_addr_i`=10 → LSU req is high the next cycle. With `ISSUE_WB_BYPASS_EN`, it is high in the same cycle.
- **Full/wrap:**
  - Stimulus: DEPTH=4, all unit acks low; enqueue 5.
  - Response: `ack_o` drops after 4 and count_o=4.
  - Then drain 4 and enqueue 6 more: order is preserved across pointer wrap.
- **x0/same-cycle:**
  - An op writing x0 leaves `busy` clear.
  - Dispatch writing x5 in the same cycle as writeback of x5 leaves `busy[5]`=1.
- **Flush:** 3 queued entries, raise `flush_i` → next cycle count_o=0, `unit_req_o`=0, and `busy` bits from already-dispatched ops are retained.
- **Reset mid-op:** assert `rst_i` asynchronously while `unit_req_o`=001 and unacked → outputs are 0 immediately and count_o=0.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared types for the in-order issue queue: unit selector, queued micro-op entry, widths.
package issue_queue_pkg;
  localparam int ISSUE_OP_W  = 8;
  localparam int ISSUE_XLEN  = 32;
  localparam int ISSUE_RA_W  = 5;

  typedef enum logic [1:0] {
    UNIT_ALU    = 2'd0,
    UNIT_PC_ALU = 2'd1,
    UNIT_LSU    = 2'd2
  } unit_sel_e;

  typedef struct packed {
    unit_sel_e               unit;
    logic [ISSUE_OP_W-1:0]   op;
    logic [ISSUE_RA_W-1:0]   raddr_a;
    logic [ISSUE_RA_W-1:0]   raddr_b;
    logic                    use_a;
    logic                    use_b;
    logic [ISSUE_RA_W-1:0]   waddr;
    logic                    we;
    logic [ISSUE_XLEN-1:0]   imm;
    logic [ISSUE_XLEN-1:0]   pc;
  } issue_entry_t;
endpackage

// File: rtl/issue_queue_if.sv
// Decode-side enqueue, unit dispatch, writeback and flush signals of the issue queue.
// Signal suffixes are from the queue's point of view (slave = queue, master = environment).
interface issue_queue_if #(
  parameter int NUM_UNITS = 3,
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4
);
  import issue_queue_pkg::*;
  localparam int UW = $clog2(NUM_UNITS);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  req_i;
  logic                  ack_o;
  logic [UW-1:0]         unit_i;
  logic [ISSUE_OP_W-1:0] op_i;
  logic [4:0]            raddr_a_i;
  logic [4:0]            raddr_b_i;
  logic                  use_a_i;
  logic                  use_b_i;
  logic [4:0]            waddr_i;
  logic                  we_i;
  logic [XLEN-1:0]       imm_i;
  logic [XLEN-1:0]       pc_i;
  logic [NUM_UNITS-1:0]  unit_req_o;
  logic [NUM_UNITS-1:0]  unit_ack_i;
  logic [ISSUE_OP_W-1:0] d_op_o;
  logic [4:0]            d_raddr_a_o;
  logic [4:0]            d_raddr_b_o;
  logic [4:0]            d_waddr_o;
  logic                  d_we_o;
  logic [XLEN-1:0]       d_imm_o;
  logic [XLEN-1:0]       d_pc_o;
  logic                  wb_valid_i;
  logic [4:0]            wb_addr_i;
  logic                  flush_i;
  logic [CW-1:0]         count_o;

  modport slave (
    input  req_i, unit_i, op_i, raddr_a_i, raddr_b_i, use_a_i, use_b_i, waddr_i, we_i,
           imm_i, pc_i, unit_ack_i, wb_valid_i, wb_addr_i, flush_i,
    output ack_o, unit_req_o, d_op_o, d_raddr_a_o, d_raddr_b_o, d_waddr_o, d_we_o,
           d_imm_o, d_pc_o, count_o
  );

  modport master (
    output req_i, unit_i, op_i, raddr_a_i, raddr_b_i, use_a_i, use_b_i, waddr_i, we_i,
           imm_i, pc_i, unit_ack_i, wb_valid_i, wb_addr_i, flush_i,
    input  ack_o, unit_req_o, d_op_o, d_raddr_a_o, d_raddr_b_o, d_waddr_o, d_we_o,
           d_imm_o, d_pc_o, count_o
  );
endinterface

// File: rtl/issue_queue_scoreboard.sv
// Register busy tracking for the issue queue. Optional macro ISSUE_WB_BYPASS_EN lets a
// writeback in the current cycle already hide the busy bit from the hazard check.
module issue_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          set_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic          clr_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic [AW-1:0] chk_a_i,
  input  logic [AW-1:0] chk_b_i,
  input  logic [AW-1:0] chk_w_i,
  output logic          busy_a_o,
  output logic          busy_b_o,
  output logic          busy_w_o
);
  logic [NREG-1:0] busy_q, busy_d, clr_mask, set_mask, view;

  // Set is applied after clear so a dispatch beats a same-cycle writeback.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr_i) clr_mask[clr_addr_i] = 1'b1;
    if (set_i) set_mask[set_addr_i] = 1'b1;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

`ifdef ISSUE_WB_BYPASS_EN
  assign view = busy_q & ~clr_mask;
`else
  assign view = busy_q;
`endif

  assign busy_a_o = view[chk_a_i];
  assign busy_b_o = view[chk_b_i];
  assign busy_w_o = view[chk_w_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end
endmodule

// File: rtl/issue_queue.sv
// In-order issue FIFO with RAW/WAW scoreboard and one-hot per-unit dispatch handshake.
// Build option ISSUE_WB_BYPASS_EN (see issue_scoreboard) removes one cycle of writeback latency.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int NUM_UNITS = 3,
  parameter int XLEN      = 32,
  parameter int NREG      = 32
) (
  input logic         clk_i,
  input logic         rst_i,
  issue_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  issue_entry_t         mem_q [DEPTH];
  issue_entry_t         head_e, in_e;
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full, empty, enq, disp, blocked;
  logic                 busy_a, busy_b, busy_w;
  logic [NUM_UNITS-1:0] req_vec;

  assign head_e = mem_q[head_q];
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);

  // No pass-through when full, even if the head leaves this cycle.
  assign bus.ack_o = !rst_i && !full && !bus.flush_i;
  assign enq       = bus.req_i && bus.ack_o;

  assign in_e = '{unit:    unit_sel_e'(bus.unit_i),
                  op:      bus.op_i,
                  raddr_a: bus.raddr_a_i,
                  raddr_b: bus.raddr_b_i,
                  use_a:   bus.use_a_i,
                  use_b:   bus.use_b_i,
                  waddr:   bus.waddr_i,
                  we:      bus.we_i,
                  imm:     ISSUE_XLEN'(bus.imm_i),
                  pc:      ISSUE_XLEN'(bus.pc_i)};

  assign blocked = (head_e.use_a && busy_a) || (head_e.use_b && busy_b) || (head_e.we && busy_w);

  always_comb begin
    req_vec = '0;
    if (!empty && !blocked && !bus.flush_i && !rst_i)
      req_vec = NUM_UNITS'(1) << head_e.unit;
  end

  assign bus.unit_req_o = req_vec;
  assign disp           = |(req_vec & bus.unit_ack_i);

  assign bus.d_op_o      = head_e.op;
  assign bus.d_raddr_a_o = head_e.raddr_a;
  assign bus.d_raddr_b_o = head_e.raddr_b;
  assign bus.d_waddr_o   = head_e.waddr;
  assign bus.d_we_o      = head_e.we;
  assign bus.d_imm_o     = head_e.imm[XLEN-1:0];
  assign bus.d_pc_o      = head_e.pc[XLEN-1:0];
  assign bus.count_o     = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush_i) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (enq)  tail_d = tail_q + 1'b1;
      if (disp) head_d = head_q + 1'b1;
      if (enq && !disp)      count_d = count_q + 1'b1;
      else if (!enq && disp) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (enq) mem_q[tail_q] <= in_e;
    end
  end

  issue_scoreboard #(.NREG(NREG)) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (disp && head_e.we),
    .set_addr_i (head_e.waddr),
    .clr_i      (bus.wb_valid_i),
    .clr_addr_i (bus.wb_addr_i),
    .chk_a_i    (head_e.raddr_a),
    .chk_b_i    (head_e.raddr_b),
    .chk_w_i    (head_e.waddr),
    .busy_a_o   (busy_a),
    .busy_b_o   (busy_b),
    .busy_w_o   (busy_w)
  );
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus random traffic, checked by a queue-based
// reference model in a negedge monitor.
module tb_issue_queue;
  import issue_queue_pkg::*;
  localparam int DEPTH = 4, NUM_UNITS = 3, XLEN = 32, NREG = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  issue_queue_if #(.NUM_UNITS(NUM_UNITS), .XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  issue_queue #(.DEPTH(DEPTH), .NUM_UNITS(NUM_UNITS), .XLEN(XLEN), .NREG(NREG)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  issue_entry_t    mq[$];
  logic [NREG-1:0] busy_m = '0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: occupancy is the queue size, dispatch order is queue order.
  always @(negedge clk) begin : monitor
    issue_entry_t    h;
    logic [NREG-1:0] view;
    logic [2:0]      ereq;
    logic            eack, blk, edisp;
    if (rst) begin
      mq.delete();
      busy_m = '0;
      check("rst_mon_ack", bus.ack_o, 0);
      check("rst_mon_req", bus.unit_req_o, 0);
      check("rst_mon_count", bus.count_o, 0);
    end else begin
      eack = (mq.size() < DEPTH) && !bus.flush_i;
      view = busy_m;
`ifdef ISSUE_WB_BYPASS_EN
      if (bus.wb_valid_i) view[bus.wb_addr_i] = 1'b0;
`endif
      ereq = '0;
      h    = '0;
      if (mq.size() > 0) begin
        h   = mq[0];
        blk = (h.use_a && view[h.raddr_a]) || (h.use_b && view[h.raddr_b]) || (h.we && view[h.waddr]);
        if (!blk && !bus.flush_i) ereq = 3'(1 << h.unit);
        check("payload", {bus.d_op_o, bus.d_raddr_a_o, bus.d_raddr_b_o, bus.d_waddr_o, bus.d_we_o},
              {h.op, h.raddr_a, h.raddr_b, h.waddr, h.we});
        check("payload_imm_pc", {bus.d_imm_o, bus.d_pc_o}, {h.imm, h.pc});
      end
      check("count", bus.count_o, mq.size());
      check("ack", bus.ack_o, eack);
      check("unit_req", bus.unit_req_o, ereq);
      edisp = |(ereq & bus.unit_ack_i);
      if (bus.flush_i) mq.delete();
      else begin
        if (edisp) void'(mq.pop_front());
        if (bus.req_i && eack)
          mq.push_back('{unit: unit_sel_e'(bus.unit_i), op: bus.op_i, raddr_a: bus.raddr_a_i,
                         raddr_b: bus.raddr_b_i, use_a: bus.use_a_i, use_b: bus.use_b_i,
                         waddr: bus.waddr_i, we: bus.we_i, imm: bus.imm_i, pc: bus.pc_i});
      end
      if (bus.wb_valid_i) busy_m[bus.wb_addr_i] = 1'b0;
      if (edisp && h.we && h.waddr != 0) busy_m[h.waddr] = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.req_i = 0; bus.unit_i = 0; bus.op_i = 0; bus.raddr_a_i = 0; bus.raddr_b_i = 0;
    bus.use_a_i = 0; bus.use_b_i = 0; bus.waddr_i = 0; bus.we_i = 0; bus.imm_i = 0; bus.pc_i = 0;
    bus.unit_ack_i = 0; bus.wb_valid_i = 0; bus.wb_addr_i = 0; bus.flush_i = 0;
  endtask

  task automatic drive_op(input int unit, input logic [7:0] op, input logic [4:0] ra, input logic [4:0] rb,
                          input logic ua, input logic ub, input logic [4:0] wa, input logic we);
    bus.req_i = 1; bus.unit_i = 2'(unit); bus.op_i = op; bus.raddr_a_i = ra; bus.raddr_b_i = rb;
    bus.use_a_i = ua; bus.use_b_i = ub; bus.waddr_i = wa; bus.we_i = we;
    bus.imm_i = $urandom; bus.pc_i = $urandom;
  endtask

  initial begin
    int sent, budget;
    logic acc;
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_count", bus.count_o, 0);
    check("rst_ack", bus.ack_o, 0);
    check("rst_d_op", bus.d_op_o, 0);
    tick();
    rst = 0;

    // Reset/flow: ALU x1,x2 -> x10
    drive_op(0, 8'h11, 1, 2, 1, 1, 10, 1); tick(); bus.req_i = 0;
    @(negedge clk); check("flow_req", bus.unit_req_o, 3'b001);
    tick(); bus.unit_ack_i = 3'b001; tick(); bus.unit_ack_i = 0;
    @(negedge clk);
    check("flow_count", bus.count_o, 0);
    check("flow_busy10", dut.u_sb.busy_q[10], 1);

    // RAW on x10
    tick(); drive_op(2, 8'h22, 10, 0, 1, 0, 0, 0); tick(); bus.req_i = 0;
    @(negedge clk); check("raw_block", bus.unit_req_o, 3'b000);
    tick(); bus.wb_valid_i = 1; bus.wb_addr_i = 10;
    @(negedge clk);
`ifdef ISSUE_WB_BYPASS_EN
    check("raw_wb_same", bus.unit_req_o, 3'b100);
`else
    check("raw_wb_same", bus.unit_req_o, 3'b000);
`endif
    tick(); bus.wb_valid_i = 0;
    @(negedge clk); check("raw_wb_next", bus.unit_req_o, 3'b100);
    tick(); bus.unit_ack_i = 3'b100; tick(); bus.unit_ack_i = 0;

    // Full, then drain while refilling across pointer wrap
    for (int k = 0; k < 5; k++) begin
      drive_op(0, 8'(8'h40 + k), 0, 0, 0, 0, 0, 0);
      if (k == 4) begin
        @(negedge clk);
        check("full_ack", bus.ack_o, 0);
        check("full_count", bus.count_o, 4);
      end
      tick();
    end
    bus.req_i = 0;
    bus.unit_ack_i = 3'b001;
    sent = 0; budget = 0;
    while (sent < 6 && budget < 50) begin
      drive_op(0, 8'(8'h60 + sent), 0, 0, 0, 0, 0, 0);
      @(negedge clk); acc = bus.ack_o;
      tick();
      if (acc) sent++;
      budget++;
    end
    check("wrap_sent", sent, 6);
    bus.req_i = 0;
    repeat (12) tick();
    @(negedge clk); check("wrap_count", bus.count_o, 0);

    // x0 write never marks busy
    tick(); drive_op(0, 8'h50, 0, 0, 0, 0, 0, 1); tick(); bus.req_i = 0; tick();
    @(negedge clk); check("x0_busy", dut.u_sb.busy_q, 0);

    // Dispatch of x5 and writeback of x5 in the same cycle: set wins
    tick(); drive_op(0, 8'h51, 0, 0, 0, 0, 5, 1); tick(); bus.req_i = 0;
    bus.wb_valid_i = 1; bus.wb_addr_i = 5; tick(); bus.wb_valid_i = 0; bus.unit_ack_i = 0;
    @(negedge clk); check("setwins_busy5", dut.u_sb.busy_q[5], 1);
    tick(); bus.wb_valid_i = 1; bus.wb_addr_i = 5; tick(); bus.wb_valid_i = 0;

    // Flush keeps scoreboard state of already-dispatched writes
    bus.unit_ack_i = 3'b001; drive_op(0, 8'h55, 0, 0, 0, 0, 7, 1); tick(); bus.req_i = 0;
    tick(); bus.unit_ack_i = 0;
    for (int k = 0; k < 3; k++) begin drive_op(1, 8'(8'h70 + k), 1, 2, 1, 1, 0, 0); tick(); end
    bus.req_i = 0; bus.flush_i = 1; tick(); bus.flush_i = 0;
    @(negedge clk);
    check("flush_count", bus.count_o, 0);
    check("flush_req", bus.unit_req_o, 0);
    check("flush_busy7", dut.u_sb.busy_q[7], 1);
    tick(); bus.wb_valid_i = 1; bus.wb_addr_i = 7; tick(); bus.wb_valid_i = 0;

    // Asynchronous reset while a request is pending
    drive_op(0, 8'h77, 1, 2, 1, 1, 0, 0); tick(); bus.req_i = 0;
    @(negedge clk); check("mid_req_before", bus.unit_req_o, 3'b001);
    #2 rst = 1;
    #1;
    check("mid_req", bus.unit_req_o, 0);
    check("mid_count", bus.count_o, 0);
    check("mid_ack", bus.ack_o, 0);
    check("mid_d_op", bus.d_op_o, 0);
    tick(); tick(); rst = 0;

    // Random traffic on a small register window to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) != 0)
        drive_op($urandom_range(2), 8'($urandom), 5'($urandom_range(7)), 5'($urandom_range(7)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(7)), 1'($urandom));
      else bus.req_i = 0;
      bus.unit_ack_i = 3'($urandom);
      bus.wb_valid_i = 1'($urandom);
      bus.wb_addr_i  = 5'($urandom_range(7));
      bus.flush_i    = ($urandom_range(63) == 0);
      tick();
    end
    idle_in();
    bus.unit_ack_i = 3'b111;
    for (int c = 0; c < 48; c++) begin
      bus.wb_valid_i = 1; bus.wb_addr_i = 5'(c % 8);
      tick();
    end
    idle_in();
    @(negedge clk); check("drain_count", bus.count_o, 0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
